alu_mc: RTL and testbench

Parametrised multi-cycle ALU, the next-generation execute-stage ALU for the WISC-SP13 pipeline. Single-cycle ops (add/sub, logic, shift/rotate, set-compare, bit reverse) complete with a registered result after one cycle. Iterative unsigned multiply, divide and remainder take WIDTH iterations. A valid/ready handshake on both sides lets the execute stage stall on long ops instead of the whole core being sized for them.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_iter.sv | 110 +++++++++++
 rtl/alu_mc.sv | 170 +++++++++++++++++
 tb/tb_alu_mc.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared op codes, FSM state encoding and shift-amount width for alu_mc.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_XOR  = 4'd2,
        OP_ANDN = 4'd3,
        OP_ROL  = 4'd4,
        OP_SLL  = 4'd5,
        OP_ROR  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SEQ  = 4'd8,
        OP_SLT  = 4'd9,
        OP_SLE  = 4'd10,
        OP_SCO  = 4'd11,
        OP_MUL  = 4'd12,
        OP_DIVU = 4'd13,
        OP_REMU = 4'd14,
        OP_BTR  = 4'd15
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;

    function automatic int shamt_width(input int width);
        return $clog2(width);
    endfunction

    localparam int SHAMT_W = shamt_width(DEFAULT_WIDTH);

endpackage

`default_nettype wire

// File: rtl/alu_iter.sv
// ============================================================================
// Module      : alu_iter
// Description : Iterative shift-add multiplier / restoring divider with step counter.
//               Divider datapath is built only when ALU_MC_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step_en,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH);

    // r_acc: partial product or partial remainder; r_sh: multiplier or dividend/quotient
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_mc;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_sh_nxt;
    logic [WIDTH-1:0] w_mc_nxt;

`ifdef ALU_MC_DIV_EN
    logic             r_div;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;

    assign w_trial = {r_acc, r_sh[WIDTH-1]};
    assign w_ge    = (w_trial >= {1'b0, r_mc});

    always_comb begin
        w_acc_nxt = r_sh[0] ? (r_acc + r_mc) : r_acc;
        w_sh_nxt  = r_sh >> 1;
        w_mc_nxt  = r_mc << 1;
        if (r_div) begin
            // Partial remainder stays below the divisor, so WIDTH bits suffice
            w_acc_nxt = w_ge ? (w_trial[WIDTH-1:0] - r_mc) : w_trial[WIDTH-1:0];
            w_sh_nxt  = {r_sh[WIDTH-2:0], w_ge};
            w_mc_nxt  = r_mc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= 1'b0;
        end else if (start) begin
            r_div <= is_div;
        end
    end
`else
    logic w_unused_is_div;
    assign w_unused_is_div = is_div;

    always_comb begin
        w_acc_nxt = r_sh[0] ? (r_acc + r_mc) : r_acc;
        w_sh_nxt  = r_sh >> 1;
        w_mc_nxt  = r_mc << 1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_sh  <= '0;
            r_mc  <= '0;
        end else if (start) begin
            r_cnt <= CNT_W'(WIDTH - 1);
            r_acc <= '0;
`ifdef ALU_MC_DIV_EN
            r_sh  <= is_div ? a : b;
            r_mc  <= is_div ? b : a;
`else
            r_sh  <= b;
            r_mc  <= a;
`endif
        end else if (step_en) begin
            r_acc <= w_acc_nxt;
            r_sh  <= w_sh_nxt;
            r_mc  <= w_mc_nxt;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Outputs include the step in flight so the caller can latch on the last step
    assign done      = (r_cnt == '0);
    assign product   = w_acc_nxt;
    assign quotient  = w_sh_nxt;
    assign remainder = w_acc_nxt;

endmodule

`default_nettype wire

// File: rtl/alu_mc.sv
// ============================================================================
// Module      : alu_mc
// Description : Multi-cycle execute-stage ALU with valid/ready handshake.
//               Define ALU_MC_DIV_EN to build the DIVU/REMU datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             n,
    output logic             p,
    output logic             err,
    output logic             busy
);

    localparam int         SH_W    = $clog2(WIDTH);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_ITER = ITER;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_err;
    logic [3:0]       r_op;

    logic             w_accept;
    logic             w_start;
    logic             w_is_div;
    logic             w_done;
    logic [WIDTH-1:0] w_product;
    logic [WIDTH-1:0] w_quotient;
    logic [WIDTH-1:0] w_remainder;
    logic [WIDTH-1:0] w_single;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_ovf;
    logic             w_lt;
    logic             w_eq;
    logic [SH_W-1:0]  w_shamt;
    logic [SH_W-1:0]  w_shamt_neg;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;

    assign in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_ITER);
    assign w_accept  = in_valid & in_ready;
    assign w_is_div  = (op == OP_DIVU) | (op == OP_REMU);

`ifdef ALU_MC_DIV_EN
    assign w_start = w_accept & ((op == OP_MUL) | (w_is_div & (b != '0)));
`else
    assign w_start = w_accept & (op == OP_MUL);
`endif

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = a - b;
    // Signed a<b is the sign of a-b corrected for two's-complement overflow
    assign w_ovf  = (a[WIDTH-1] ^ b[WIDTH-1]) & (w_diff[WIDTH-1] ^ a[WIDTH-1]);
    assign w_lt   = w_diff[WIDTH-1] ^ w_ovf;
    assign w_eq   = (a == b);

    // Shift by (WIDTH - s) mod WIDTH, so a zero amount degenerates to a | a
    assign w_shamt     = b[SH_W-1:0];
    assign w_shamt_neg = SH_W'(0) - w_shamt;
    assign w_rol       = (a << w_shamt) | (a >> w_shamt_neg);
    assign w_ror       = (a >> w_shamt) | (a << w_shamt_neg);

    always_comb begin
        w_single = '0;
        case (op)
            OP_ADD:  w_single = w_sum[WIDTH-1:0];
            OP_SUB:  w_single = w_diff;
            OP_XOR:  w_single = a ^ b;
            OP_ANDN: w_single = a & ~b;
            OP_ROL:  w_single = w_rol;
            OP_SLL:  w_single = a << w_shamt;
            OP_ROR:  w_single = w_ror;
            OP_SRL:  w_single = a >> w_shamt;
            OP_SEQ:  w_single = {{(WIDTH-1){1'b0}}, w_eq};
            OP_SLT:  w_single = {{(WIDTH-1){1'b0}}, w_lt};
            OP_SLE:  w_single = {{(WIDTH-1){1'b0}}, w_lt | w_eq};
            OP_SCO:  w_single = {{(WIDTH-1){1'b0}}, w_sum[WIDTH]};
            OP_BTR: begin
                for (int i = 0; i < WIDTH; i++) begin
                    w_single[i] = a[WIDTH-1-i];
                end
            end
            default: w_single = '0;
        endcase
    end

    alu_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .is_div   (w_is_div),
        .a        (a),
        .b        (b),
        .step_en  (busy),
        .done     (w_done),
        .product  (w_product),
        .quotient (w_quotient),
        .remainder(w_remainder)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_err    <= 1'b0;
            r_op     <= 4'd0;
        end else if (w_accept) begin
            r_op  <= op;
            r_err <= 1'b0;
            if (op == OP_MUL) begin
                r_state <= ST_ITER;
            end else if (w_is_div) begin
`ifdef ALU_MC_DIV_EN
                if (b == '0) begin
                    r_state  <= ST_DONE;
                    r_err    <= 1'b1;
                    r_result <= (op == OP_DIVU) ? '1 : a;
                end else begin
                    r_state <= ST_ITER;
                end
`else
                r_state  <= ST_DONE;
                r_err    <= 1'b1;
                r_result <= '0;
`endif
            end else begin
                r_state  <= ST_DONE;
                r_result <= w_single;
            end
        end else if ((r_state == ST_ITER) && w_done) begin
            r_state  <= ST_DONE;
            r_result <= (r_op == OP_MUL)  ? w_product  :
                        (r_op == OP_DIVU) ? w_quotient : w_remainder;
        end else if ((r_state == ST_DONE) && out_ready) begin
            r_state <= ST_IDLE;
        end
    end

    assign result = r_result;
    assign err    = r_err;
    assign z      = (r_result == '0);
    assign n      = r_result[WIDTH-1];
    assign p      = ~z & ~n;

endmodule

`default_nettype wire

// File: tb/tb_alu_mc.sv
// ============================================================================
// Module      : tb_alu_mc
// Description : Directed self-checking bench for alu_mc (WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mc;
    import alu_pkg::*;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             z;
    logic             n;
    logic             p;
    logic             err;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    alu_mc #(
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .z        (z),
        .n        (n),
        .p        (p),
        .err      (err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        tick();
        in_valid = 1'b0;
    endtask

    // Flags packed as {z, n, p, err}
    task automatic check_out(input string tag, input logic [15:0] exp_res, input logic [3:0] exp_flags);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".result"}, 32'(result), 32'(exp_res));
        check({tag, ".flags"}, 32'({z, n, p, err}), 32'(exp_flags));
    endtask

    // Edges from accept to out_valid, counting busy and in_ready cycles on the way
    task automatic wait_done(output int edges, output int busy_cyc, output int ready_cyc);
        edges     = 1;
        busy_cyc  = 0;
        ready_cyc = 0;
        while (!out_valid && edges < 60) begin
            if (busy) busy_cyc++;
            if (in_ready) ready_cyc++;
            tick();
            edges++;
        end
    endtask

    int lat;
    int bcyc;
    int rcyc;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 4'd0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst.result", 32'(result), 32'h0);
        check("rst.flags", 32'({z, n, p, err}), 32'b1000);
        check("rst.ctrl", 32'({out_valid, busy, in_ready}), 32'b001);
        rst = 1'b0;
        tick();
        check("idle.in_ready", 32'(in_ready), 32'd1);

        // Single-cycle ops, back-to-back with out_ready held high
        issue(OP_ADD, 16'h7FFF, 16'h0001);  check_out("add_ovf", 16'h8000, 4'b0100);
        issue(OP_SCO, 16'h7FFF, 16'h0001);  check_out("sco0", 16'h0000, 4'b1000);
        issue(OP_SCO, 16'hFFFF, 16'h0001);  check_out("sco1", 16'h0001, 4'b0010);
        issue(OP_SLT, 16'h8000, 16'h7FFF);  check_out("slt_neg", 16'h0001, 4'b0010);
        issue(OP_SLT, 16'h7FFF, 16'h8000);  check_out("slt_pos", 16'h0000, 4'b1000);
        issue(OP_SLE, 16'h1234, 16'h1234);  check_out("sle_eq", 16'h0001, 4'b0010);
        issue(OP_SLE, 16'h8000, 16'h7FFF);  check_out("sle_lt", 16'h0001, 4'b0010);
        issue(OP_SEQ, 16'h0005, 16'h0006);  check_out("seq_ne", 16'h0000, 4'b1000);
        issue(OP_SUB, 16'h0003, 16'h0005);  check_out("sub", 16'hFFFE, 4'b0100);
        issue(OP_XOR, 16'hA5A5, 16'hFFFF);  check_out("xor", 16'h5A5A, 4'b0010);
        issue(OP_ANDN, 16'hF0F0, 16'hFF00); check_out("andn", 16'h00F0, 4'b0010);
        issue(OP_SLL, 16'h0001, 16'h0013);  check_out("sll_mask", 16'h0008, 4'b0010);
        issue(OP_SRL, 16'h8000, 16'h000F);  check_out("srl", 16'h0001, 4'b0010);
        issue(OP_ROR, 16'h0001, 16'h0001);  check_out("ror", 16'h8000, 4'b0100);
        issue(OP_ROL, 16'h8001, 16'h0000);  check_out("rol0", 16'h8001, 4'b0100);
        issue(OP_BTR, 16'h1234, 16'h0000);  check_out("btr", 16'h2C48, 4'b0010);

        // Multiply; operands are scrambled after accept to prove they were captured
        issue(OP_MUL, 16'h0123, 16'h0045);
        a  = 16'hFFFF;
        b  = 16'hFFFF;
        op = OP_ADD;
        wait_done(lat, bcyc, rcyc);
        check("mul.latency", 32'(lat), 32'd17);
        check("mul.busy", 32'(bcyc), 32'd16);
        check("mul.in_ready", 32'(rcyc), 32'd0);
        check_out("mul", 16'h4E6F, 4'b0010);

`ifdef ALU_MC_DIV_EN
        issue(OP_DIVU, 16'd100, 16'd7);
        wait_done(lat, bcyc, rcyc);
        check("divu.latency", 32'(lat), 32'd17);
        check_out("divu", 16'd14, 4'b0010);
        issue(OP_REMU, 16'd100, 16'd7);
        wait_done(lat, bcyc, rcyc);
        check("remu.latency", 32'(lat), 32'd17);
        check_out("remu", 16'd2, 4'b0010);
        issue(OP_DIVU, 16'd100, 16'd0);     check_out("divu_b0", 16'hFFFF, 4'b0101);
        issue(OP_REMU, 16'h0042, 16'd0);    check_out("remu_b0", 16'h0042, 4'b0011);
`else
        issue(OP_DIVU, 16'd100, 16'd7);     check_out("divu_off", 16'h0000, 4'b1001);
        issue(OP_REMU, 16'd100, 16'd7);     check_out("remu_off", 16'h0000, 4'b1001);
`endif
        issue(OP_ADD, 16'h0001, 16'h0001);  check_out("err_clear", 16'h0002, 4'b0010);

        // Back-pressure: result held while a queued SRL waits
        tick();
        check("to_idle.out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        issue(OP_ROL, 16'h8001, 16'h0001);
        in_valid = 1'b1;
        op       = OP_SRL;
        a        = 16'h8000;
        b        = 16'h0004;
        for (int i = 0; i < 5; i++) begin
            check("bp.result", 32'(result), 32'h0003);
            check("bp.hold", 32'({out_valid, in_ready}), 32'b10);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_out("bp.srl", 16'h0800, 4'b0010);
        tick();
        check("bp.drain", 32'(out_valid), 32'd0);

        // Asynchronous reset on the 8th iteration cycle of a multiply
        issue(OP_MUL, 16'h0123, 16'h0045);
        repeat (7) tick();
        check("abort.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort.ctrl", 32'({out_valid, busy}), 32'b00);
        check("abort.result", 32'(result), 32'h0);
        tick();
        rst = 1'b0;
        issue(OP_ADD, 16'h0002, 16'h0003);  check_out("post_rst_add", 16'h0005, 4'b0010);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
